mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 138 +++++++++++++
 tb/tb_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Command-driven memory responder: single-word write/read and multi-word clear
// against a handshaked RAM port, with a per-access ack timeout.
module mem_responder #(
  parameter int unsigned CLEAR_WORDS = 256,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioDone,
  input  logic [1:0]  modeOutput,
  input  logic [24:0] memoryAddress,
  input  logic [15:0] ioDataOut,
  output logic        memDone,
  output logic [15:0] memOut,
  output logic        memErr,
  output logic [24:0] ramAddr,
  output logic [15:0] ramWrData,
  output logic        ramWe,
  output logic        ramRe,
  input  logic        ramAck,
  input  logic [15:0] ramRdData
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CLEAR, DONE} state_t;

  localparam logic [15:0] LAST_WORD = 16'(CLEAR_WORDS - 1);
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] waitCnt;
  logic [15:0] wordCnt;
  logic        timedOut;

  // The edge that would bring waitCnt up to TIMEOUT is the abort edge, so a
  // request stays up for exactly TIMEOUT cycles when no ack arrives.
  always_comb begin
    timedOut = (waitCnt == LAST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      memDone   <= 1'b1;
      memErr    <= 1'b0;
      memOut    <= '0;
      ramAddr   <= '0;
      ramWrData <= '0;
      ramWe     <= 1'b0;
      ramRe     <= 1'b0;
      waitCnt   <= '0;
      wordCnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ioDone && modeOutput != 2'b00) begin
            ramAddr <= memoryAddress;
            memErr  <= 1'b0;
            memDone <= 1'b0;
            waitCnt <= '0;
            wordCnt <= '0;
            case (modeOutput)
              2'b01: begin
                state     <= CLEAR;
                ramWe     <= 1'b1;
                ramWrData <= '0;
              end
              2'b10: begin
                state     <= WRITE;
                ramWe     <= 1'b1;
                ramWrData <= ioDataOut;
              end
              default: begin
                state     <= READ;
                ramRe     <= 1'b1;
                ramWrData <= ioDataOut;
              end
            endcase
          end
        end

        WRITE: begin
          if (ramAck) begin
            ramWe <= 1'b0;
            state <= DONE;
          end else if (timedOut) begin
            ramWe  <= 1'b0;
            memErr <= 1'b1;
            state  <= DONE;
          end else begin
            waitCnt <= waitCnt + 16'd1;
          end
        end

        READ: begin
          if (ramAck) begin
            ramRe  <= 1'b0;
            memOut <= ramRdData;
            state  <= DONE;
          end else if (timedOut) begin
            ramRe  <= 1'b0;
            memErr <= 1'b1;
            state  <= DONE;
          end else begin
            waitCnt <= waitCnt + 16'd1;
          end
        end

        CLEAR: begin
          if (ramAck) begin
            waitCnt <= '0;
            if (wordCnt == LAST_WORD) begin
              ramWe <= 1'b0;
              state <= DONE;
            end else begin
              // ramWe stays high; next word is requested in the following cycle
              ramAddr <= ramAddr + 25'd1;
              wordCnt <= wordCnt + 16'd1;
            end
          end else if (timedOut) begin
            ramWe  <= 1'b0;
            memErr <= 1'b1;
            state  <= DONE;
          end else begin
            waitCnt <= waitCnt + 16'd1;
          end
        end

        DONE: begin
          memDone <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (CLEAR_WORDS=4, TIMEOUT=8): write, read,
// clear wrap, timeout, ignore cases and reset mid-clear.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        ioDone;
  logic [1:0]  modeOutput;
  logic [24:0] memoryAddress;
  logic [15:0] ioDataOut;
  logic        memDone;
  logic [15:0] memOut;
  logic        memErr;
  logic [24:0] ramAddr;
  logic [15:0] ramWrData;
  logic        ramWe;
  logic        ramRe;
  logic        ramAck;
  logic [15:0] ramRdData;

  int tests = 0;
  int failed = 0;
  logic [24:0] addrLog [8];
  logic [15:0] dataLog [8];
  int nLog;
  int highCycles;

  mem_responder #(.CLEAR_WORDS(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .ioDone(ioDone), .modeOutput(modeOutput),
    .memoryAddress(memoryAddress), .ioDataOut(ioDataOut), .memDone(memDone),
    .memOut(memOut), .memErr(memErr), .ramAddr(ramAddr), .ramWrData(ramWrData),
    .ramWe(ramWe), .ramRe(ramRe), .ramAck(ramAck), .ramRdData(ramRdData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse a command for one sampling edge; returns at the negedge where the
  // request is first visible.
  task automatic issue(input logic [1:0] mode, input logic [24:0] addr, input logic [15:0] data);
    @(negedge clk);
    ioDone = 1'b1; modeOutput = mode; memoryAddress = addr; ioDataOut = data;
    @(negedge clk);
    ioDone = 1'b0; modeOutput = 2'b00; memoryAddress = '0; ioDataOut = '0;
  endtask

  // Serve the request while it is up; ack on every ackAfter-th cycle since the
  // last ack (0 = never ack). Logs the address/data seen each request cycle.
  task automatic serve(input int ackAfter, input logic [15:0] rd);
    int since = 0;
    highCycles = 0;
    nLog = 0;
    while ((ramWe || ramRe) && highCycles < 200) begin
      check("exclusive", 32'(ramWe && ramRe), 32'd0);
      if (nLog < 8) begin
        addrLog[nLog] = ramAddr;
        dataLog[nLog] = ramWrData;
        nLog++;
      end
      highCycles++;
      since++;
      ramAck = (ackAfter != 0 && since == ackAfter);
      if (ramAck) since = 0;
      ramRdData = rd;
      @(negedge clk);
      ramAck = 1'b0;
      ramRdData = 16'h0000;
    end
    check("reqBound", 32'(highCycles < 200), 32'd1);
  endtask

  // Called at the first negedge with the request dropped (DONE state).
  task automatic finish(input string tag, input logic expErr);
    check({tag, ".doneLow"}, 32'(memDone), 32'd0);
    @(negedge clk);
    check({tag, ".doneHigh"}, 32'(memDone), 32'd1);
    check({tag, ".err"}, 32'(memErr), 32'(expErr));
  endtask

  task automatic idleQuiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, ".noReq"}, 32'({ramWe, ramRe}), 32'd0);
      check({tag, ".done"}, 32'(memDone), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; ioDone = 1'b0; modeOutput = 2'b00; memoryAddress = '0;
    ioDataOut = '0; ramAck = 1'b0; ramRdData = '0;
    repeat (2) @(negedge clk);
    check("rst.memDone", 32'(memDone), 32'd1);
    check("rst.memErr", 32'(memErr), 32'd0);
    check("rst.memOut", 32'(memOut), 32'd0);
    check("rst.req", 32'({ramWe, ramRe}), 32'd0);
    check("rst.ramAddr", 32'(ramAddr), 32'd0);
    check("rst.ramWrData", 32'(ramWrData), 32'd0);
    reset = 1'b0;
    idleQuiet("postRst", 2);

    // Write, ack on third request cycle
    issue(2'b10, 25'h0000123, 16'hBEEF);
    check("wr.memDoneLow", 32'(memDone), 32'd0);
    serve(3, 16'h0000);
    check("wr.cycles", 32'(highCycles), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("wr.addr", 32'(addrLog[i]), 32'h0000123);
      check("wr.data", 32'(dataLog[i]), 32'h0000BEEF);
    end
    finish("wr", 1'b0);

    // Read, ack on second request cycle
    issue(2'b11, 25'h0000123, 16'h0000);
    check("rd.isRead", 32'({ramWe, ramRe}), 32'd1);
    serve(2, 16'hBEEF);
    check("rd.cycles", 32'(highCycles), 32'd2);
    check("rd.addr", 32'(addrLog[0]), 32'h0000123);
    check("rd.reDropped", 32'(ramRe), 32'd0);
    finish("rd", 1'b0);
    check("rd.memOut", 32'(memOut), 32'h0000BEEF);

    // Clear across the top of the address space, immediate acks
    issue(2'b01, 25'h1FFFFFE, 16'hFFFF);
    serve(1, 16'h0000);
    check("clr.cycles", 32'(highCycles), 32'd4);
    check("clr.a0", 32'(addrLog[0]), 32'h1FFFFFE);
    check("clr.a1", 32'(addrLog[1]), 32'h1FFFFFF);
    check("clr.a2", 32'(addrLog[2]), 32'h0000000);
    check("clr.a3", 32'(addrLog[3]), 32'h0000001);
    for (int i = 0; i < 4; i++) check("clr.data", 32'(dataLog[i]), 32'd0);
    finish("clr", 1'b0);

    // Read timeout: no ack
    issue(2'b11, 25'h0000040, 16'h0000);
    serve(0, 16'h0000);
    check("to.cycles", 32'(highCycles), 32'd8);
    finish("to", 1'b1);
    check("to.memOutKept", 32'(memOut), 32'h0000BEEF);

    // Ack on the very cycle the timeout would fire is a success
    issue(2'b11, 25'h0000041, 16'h0000);
    check("edge.errCleared", 32'(memErr), 32'd0);
    serve(8, 16'h1234);
    check("edge.cycles", 32'(highCycles), 32'd8);
    finish("edge", 1'b0);
    check("edge.memOut", 32'(memOut), 32'h00001234);

    // Timeout again, then a good write clears memErr
    issue(2'b10, 25'h0000050, 16'h0001);
    serve(0, 16'h0000);
    finish("to2", 1'b1);
    issue(2'b10, 25'h0000051, 16'h0002);
    serve(1, 16'h0000);
    finish("wr2", 1'b0);

    // Mode 00 and a stray ack in IDLE are ignored
    @(negedge clk);
    ioDone = 1'b1; modeOutput = 2'b00; memoryAddress = 25'h0000777;
    ramAck = 1'b1; ramRdData = 16'hDEAD;
    @(negedge clk);
    ioDone = 1'b0; ramAck = 1'b0; ramRdData = '0;
    check("nop.noReq", 32'({ramWe, ramRe}), 32'd0);
    check("nop.memOut", 32'(memOut), 32'h00001234);
    idleQuiet("nop", 3);

    // ioDone during a write is ignored
    issue(2'b10, 25'h0000123, 16'hCAFE);
    ioDone = 1'b1; modeOutput = 2'b11; memoryAddress = 25'h0000055; ioDataOut = 16'h5555;
    @(negedge clk);
    ioDone = 1'b0; modeOutput = 2'b00; memoryAddress = '0; ioDataOut = '0;
    check("busy.addr", 32'(ramAddr), 32'h0000123);
    check("busy.data", 32'(ramWrData), 32'h0000CAFE);
    check("busy.isWrite", 32'({ramWe, ramRe}), 32'd2);
    serve(2, 16'h0000);
    check("busy.cycles", 32'(highCycles), 32'd2);
    finish("busy", 1'b0);
    idleQuiet("busy", 3);

    // Reset after two of four clear acks
    issue(2'b01, 25'h0000100, 16'h0000);
    ramAck = 1'b1;
    @(negedge clk);
    ramAck = 1'b1;
    @(negedge clk);
    ramAck = 1'b0;
    check("rmc.addr", 32'(ramAddr), 32'h0000102);
    check("rmc.we", 32'(ramWe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rmc.we0", 32'(ramWe), 32'd0);
    check("rmc.done", 32'(memDone), 32'd1);
    check("rmc.err", 32'(memErr), 32'd0);
    check("rmc.addr0", 32'(ramAddr), 32'd0);
    check("rmc.memOut", 32'(memOut), 32'd0);
    idleQuiet("rmc", 2);

    // Post-reset command restarts counters from zero
    issue(2'b01, 25'h0000200, 16'h0000);
    serve(1, 16'h0000);
    check("rmc.clrCycles", 32'(highCycles), 32'd4);
    check("rmc.clrLast", 32'(addrLog[3]), 32'h0000203);
    finish("rmc2", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
